fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction buffer between the fetch stage (PC register, PC+4 adder, instruction memory) and decode. It accepts one {PC, instruction} pair per cycle from fetch and presents them in order to decode over a valid/ready handshake. The buffer absorbs decode stalls without losing fetched words and is emptied in one cycle on a control-flow redirect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, PC and instruction width
- clk  in  1  rising-edge clock; the block uses one clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents a word
- in_ready  out  1  buffer can accept; equals count < DEPTH
- in_pc  in  XLEN  PC of the fetched word
- in_instr  in  XLEN  fetched instruction
- flush  in  1  redirect; discard all buffered entries
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  XLEN  head PC; 0 when empty
- out_instr  out  XLEN  head instruction; NOP (0x00000013) when empty
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- The storage is a circular array with write and read pointers. Each pointer is $clog2(DEPTH)+1 bits wide, and the extra MSB is the wrap bit.
- Empty condition: the pointers are equal. Full condition: the index bits are equal and the wrap bits differ. count is a register kept consistent with the pointers.
- Push: in_valid && in_ready writes {in_pc, in_instr} at wptr, then wptr is incremented.
- Pop: out_valid && out_ready increments rptr.
- When push and pop occur together, count is unchanged and both pointers advance.
- When full, in_ready is 0 even if a pop happens in the same cycle. There is no push-through on full.
- out_valid = !empty. Popping while empty has no effect.
- Flush has priority over push and pop. On the next edge, wptr = rptr = 0 and count = 0. A push in the flush cycle is dropped, and any pop in that cycle is irrelevant.
- in_ready during the flush cycle is computed from the pre-flush count. Fetch must treat a push in that cycle as discarded.
- Pointer increments wrap modulo 2·DEPTH. Entries are never reordered.

## Timing
- Reset values: wptr = 0, rptr = 0, count = 0, out_valid = 0, out_pc = 0, out_instr = 0x00000013, in_ready = 1.
- Latency from push to out_valid is 1 cycle without bypass. Throughput is one word per cycle in steady state.
- in_ready and out_valid depend only on registered state. There is no combinational path from inputs to them, except the bypass path described under Configuration.
- out_pc and out_instr are driven combinationally from the head entry and are masked to 0 / NOP when empty.
- Reset asserted mid-operation behaves like flush, and it also forces all outputs to their reset values in the following cycle. Reset wins over flush.
- Storage contents are not cleared on reset or flush. Only the pointers are cleared.

## Configuration
- FETCH_BUF_BYPASS_EN defined: when the buffer is empty and in_valid = 1, the block drives out_valid = 1, out_pc = in_pc and out_instr = in_instr combinationally.
  - If out_ready is also 1, the word is consumed in that cycle and not written, so pointers and count are unchanged.
  - If out_ready is 0, the word is written normally.
  - Bypass is suppressed when flush = 1.
- FETCH_BUF_BYPASS_EN undefined: there is no input-to-output combinational path, and minimum latency is 1 cycle.

## Structure
- Shared package fetch_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h00000013
  - typedef fetch_entry_t as a packed struct {pc, instr}
- Sub-module fetch_buf_mem is the storage array. It has a DEPTH × fetch_entry_t register array with one synchronous write port and one asynchronous read port, and no reset.
- Pointer, count and handshake logic live in fetch_buffer.

## Test plan
- Reset, then push 3 words (PC 0x0/0x00500093, 0x4/0xFFE08113, 0x8/0x00A10193) with out_ready = 0. Required: count = 3, head is PC 0x0 and instr 0x00500093, in_ready = 1.
- Fill to DEPTH = 4 with out_ready = 0. Required: in_ready = 0 and a fifth push is ignored. Then pop all with out_ready = 1. Required: PCs 0x0, 0x4, 0x8, 0xC in order, followed by out_valid = 0 and out_instr = 0x00000013.
- Continuous push and pop for 10 cycles (PC 0x0..0x24). Required: count stays at 1 (0 with bypass), the pointers wrap past 2·DEPTH, and output order matches input.
- With 2 entries held, assert flush together with in_valid (PC 0x40). Required: next cycle count = 0 and out_valid = 0. Then push PC 0x80, which must be the next head.
- Assert reset mid-stream with 3 entries. Required: next cycle count = 0, out_valid = 0, out_pc = 0, in_ready = 1.
- With FETCH_BUF_BYPASS_EN, the buffer empty and out_ready = 1, push PC 0x10. Required: out_valid = 1 and out_pc = 0x10 in the same cycle, and count remains 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_buf_mem.sv
// Storage array for fetch_buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; only the pointers in the parent define validity.
module fetch_buf_mem
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         we,
   input  logic [AW-1:0] waddr,
   input  fetch_entry_t wdata,
   input  logic [AW-1:0] raddr,
   output fetch_entry_t rdata
);
   fetch_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_buffer.sv
// In-order {PC, instruction} buffer between fetch and decode with single-cycle flush.
// Optional same-cycle bypass when empty is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IW = $clog2(DEPTH),
   localparam int PW = IW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_instr,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic [PW-1:0]   count
);
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          empty;
   logic          bypass_take;
   logic          push;
   logic          pop;
   fetch_entry_t  head;
   fetch_entry_t  wr_entry;

   assign empty    = (wptr_q == rptr_q);
   assign in_ready = (count_q < DEPTH_C);
   assign count    = count_q;

`ifdef FETCH_BUF_BYPASS_EN
   logic bypass_act;
   assign bypass_act  = empty && in_valid && !flush;
   assign bypass_take = bypass_act && out_ready;
`else
   assign bypass_take = 1'b0;
`endif

   // A word consumed through the bypass never touches storage or the pointers.
   assign push = in_valid && in_ready && !flush && !bypass_take;
   assign pop  = !empty && out_ready && !flush;

   assign wr_entry = '{pc: in_pc, instr: in_instr};

   fetch_buf_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wptr_q[IW-1:0]),
      .wdata (wr_entry),
      .raddr (rptr_q[IW-1:0]),
      .rdata (head)
   );

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      out_valid = !empty;
      out_pc    = head.pc;
      out_instr = head.instr;
      if (empty) begin
         out_pc    = '0;
         out_instr = NOP_INSTR;
      end
`ifdef FETCH_BUF_BYPASS_EN
      if (bypass_act) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_instr = in_instr;
      end
`endif
   end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scoreboard bench for fetch_buffer; follows FETCH_BUF_BYPASS_EN if defined.
module tb_fetch_buffer;
   import fetch_pkg::*;

   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_instr;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic [2:0]      count;

   int errors = 0;
   int checks = 0;
   fetch_entry_t sb[$];

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle, check against the reference model, then advance the model past the edge.
   task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rst);
      fetch_entry_t exp_head;
      logic byp, exp_ready, exp_valid, do_push, do_pop;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      #1;
      exp_ready = (sb.size() < DEPTH);
`ifdef FETCH_BUF_BYPASS_EN
      byp = (sb.size() == 0) && iv && !fl;
`else
      byp = 1'b0;
`endif
      exp_valid = (sb.size() != 0) || byp;
      if (byp)                exp_head = '{pc: pc, instr: ins};
      else if (sb.size() != 0) exp_head = sb[0];
      else                    exp_head = '{pc: 32'h0, instr: NOP_INSTR};
      chk("in_ready",  32'(in_ready),  32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("count",     32'(count),     32'(sb.size()));
      chk("out_pc",    out_pc,         exp_head.pc);
      chk("out_instr", out_instr,      exp_head.instr);
      if (rst || fl) begin
         sb.delete();
      end else begin
         do_push = iv && exp_ready && !(byp && ordy);
         do_pop  = (sb.size() != 0) && ordy;
         if (do_pop || (byp && ordy))
            $display("pop  pc=%h instr=%h", exp_head.pc, exp_head.instr);
         if (do_pop) void'(sb.pop_front());
         if (do_push) begin
            sb.push_back('{pc: pc, instr: ins});
            $display("push pc=%h instr=%h", pc, ins);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then three pushes held by a stalled decode.
      cycle(0, 32'h0, 32'h0, 0, 0, 0);
      cycle(1, 32'h0, 32'h00500093, 0, 0, 0);
      cycle(1, 32'h4, 32'hFFE08113, 0, 0, 0);
      cycle(1, 32'h8, 32'h00A10193, 0, 0, 0);
      cycle(0, 32'h0, 32'h0, 0, 0, 0);

      // Fill, attempt a push while full, then drain in order.
      cycle(1, 32'hC,  32'h00C00213, 0, 0, 0);
      cycle(1, 32'h10, 32'h01000293, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 32'h0, 32'h0, 1, 0, 0);

      // Full with a simultaneous pop: still not ready.
      for (int i = 0; i < 4; i++) cycle(1, 32'h100 + 32'(i * 4), 32'h00000113 + 32'(i), 0, 0, 0);
      cycle(1, 32'h200, 32'h00000213, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0, 0);

      // Streaming push and pop every cycle; pointers wrap past 2*DEPTH.
      for (int i = 0; i < 10; i++) cycle(1, 32'(i * 4), 32'h00100093 + 32'(i << 20), 1, 0, 0);
      cycle(0, 32'h0, 32'h0, 1, 0, 0);
      cycle(0, 32'h0, 32'h0, 1, 0, 0);

      // Flush with two entries held and a coincident push.
      cycle(1, 32'h20, 32'h00000313, 0, 0, 0);
      cycle(1, 32'h24, 32'h00000393, 0, 0, 0);
      cycle(1, 32'h40, 32'h00000413, 0, 1, 0);
      cycle(1, 32'h80, 32'h00000493, 0, 0, 0);
      cycle(0, 32'h0, 32'h0, 0, 0, 0);
      cycle(0, 32'h0, 32'h0, 1, 0, 0);

      // Reset mid-stream with three entries held.
      cycle(1, 32'h90, 32'h00000513, 0, 0, 0);
      cycle(1, 32'h94, 32'h00000593, 0, 0, 0);
      cycle(1, 32'h98, 32'h00000613, 0, 0, 0);
      cycle(1, 32'h9C, 32'h00000693, 1, 1, 1);
      cycle(0, 32'h0, 32'h0, 0, 0, 0);

      // Push into an empty buffer with decode ready (same-cycle with bypass).
      cycle(1, 32'h10, 32'h00000713, 1, 0, 0);
      cycle(0, 32'h0, 32'h0, 1, 0, 0);
      cycle(0, 32'h0, 32'h0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
